// File: rtl/montgomery_pkg.sv
// Shared types and sizing helpers for the run-time-length CIOS Montgomery multiplier.
package montgomery_pkg;

    typedef enum logic [3:0] {
        IDLE, MUL, MUL_TOP, CALC_U, RED, RED_TOP, SUB, SEL, OUT
    } state_e;

    function automatic int nw_of(input int s);
        return $clog2(s + 1);
    endfunction

    function automatic int idx_of(input int s);
        return (s > 1) ? $clog2(s) : 1;
    endfunction

endpackage

// File: rtl/mont_mac_word.sv
// Word multiply-accumulate: {carry, sum} = t + x*y + c, never overflows 2W bits.
module mont_mac_word #(
    parameter int W = 32
) (
    input  logic [W-1:0]   t,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic [W-1:0]   c,
    output logic [2*W-1:0] sum
);

    assign sum = (2*W)'(t) + (2*W)'(x) * (2*W)'(y) + (2*W)'(c);

endmodule

// File: rtl/montgomery_cios_var.sv
// Word-serial CIOS Montgomery multiply a*b*R^-1 mod m, R = 2^(W*n), n chosen per transaction.
module montgomery_cios_var
    import montgomery_pkg::*;
#(
    parameter int W = 32,
    parameter int S = 8,
    localparam int NW = nw_of(S)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NW-1:0]       n_words,
    input  logic [S-1:0][W-1:0] a,
    input  logic [S-1:0][W-1:0] b,
    input  logic [S-1:0][W-1:0] m,
    input  logic [W-1:0]        m_prime,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [S-1:0][W-1:0] result,
    output logic                err,
    output logic                busy
);

    localparam int IW = idx_of(S);
    localparam int TW = $clog2(S + 2);

    typedef logic [W-1:0]   word_t;
    typedef logic [2*W-1:0] dword_t;

    state_e state, state_nxt;

    logic [S-1:0][W-1:0] a_r, b_r, m_r, d_r;
    logic [S+1:0][W-1:0] t;
    word_t               mp_r, u, carry;
    logic [NW-1:0]       n_r;
    logic [IW-1:0]       i, j;
    logic                borrow;

    word_t               mt, mx, my, mc;
    dword_t              mac;
    logic [W:0]          diff;
    logic [TW-1:0]       jt, nt;
    logic                legal, j_last, i_last, use_d;

    assign jt     = TW'(j);
    assign nt     = TW'(n_r);
    assign legal  = (n_words != '0) && (n_words <= NW'(S));
    assign j_last = (NW'(j) == n_r - NW'(1));
    assign i_last = (NW'(i) == n_r - NW'(1));
    assign diff   = {1'b0, t[jt]} - {1'b0, m_r[j]} - {{W{1'b0}}, borrow};
    // T < 2m, so T >= m exactly when the top word is set or T - m did not borrow.
    assign use_d  = (t[nt] != '0) || !borrow;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    mont_mac_word #(.W(W)) u_mac (
        .t   (mt),
        .x   (mx),
        .y   (my),
        .c   (mc),
        .sum (mac)
    );

    // One MAC serves the product row, the u computation and the reduction row.
    always_comb begin
        mt = '0;
        mx = '0;
        my = '0;
        mc = '0;
        unique case (state)
            MUL:     begin mt = t[jt]; mx = a_r[j]; my = b_r[i]; mc = carry; end
            MUL_TOP: begin mt = t[nt]; mc = carry; end
            CALC_U:  begin mx = t[0]; my = mp_r; end
            RED:     begin mt = t[jt]; mx = u; my = m_r[j]; mc = carry; end
            RED_TOP: begin mt = t[nt]; mc = carry; end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = legal ? MUL : OUT;
            MUL:     if (j_last) state_nxt = MUL_TOP;
            MUL_TOP: state_nxt = CALC_U;
            CALC_U:  state_nxt = RED;
            RED:     if (j_last) state_nxt = RED_TOP;
            RED_TOP: state_nxt = i_last ? SUB : MUL;
            SUB:     if (j_last) state_nxt = SEL;
            SEL:     state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            m_r    <= '0;
            d_r    <= '0;
            t      <= '0;
            mp_r   <= '0;
            u      <= '0;
            carry  <= '0;
            n_r    <= '0;
            i      <= '0;
            j      <= '0;
            borrow <= 1'b0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    a_r   <= a;
                    b_r   <= b;
                    m_r   <= m;
                    mp_r  <= m_prime;
                    n_r   <= n_words;
                    t     <= '0;
                    i     <= '0;
                    j     <= '0;
                    carry <= '0;
                    err   <= !legal;
                    if (!legal) result <= '0;
                end
                MUL: begin
                    t[jt] <= mac[W-1:0];
                    carry <= mac[2*W-1:W];
                    j     <= j_last ? '0 : j + IW'(1);
                end
                MUL_TOP: begin
                    t[nt]          <= mac[W-1:0];
                    t[nt + TW'(1)] <= mac[2*W-1:W];
                end
                CALC_U: begin
                    u     <= mac[W-1:0];
                    carry <= '0;
                end
                RED: begin
                    // Column 0 sums to zero by choice of u; only its carry matters.
                    if (j != '0) t[jt - TW'(1)] <= mac[W-1:0];
                    carry <= mac[2*W-1:W];
                    j     <= j_last ? '0 : j + IW'(1);
                end
                RED_TOP: begin
                    t[nt - TW'(1)] <= mac[W-1:0];
                    t[nt]          <= t[nt + TW'(1)] + mac[2*W-1:W];
                    i              <= i + IW'(1);
                    carry          <= '0;
                    borrow         <= 1'b0;
                end
                SUB: begin
                    d_r[j] <= diff[W-1:0];
                    borrow <= diff[W];
                    j      <= j_last ? '0 : j + IW'(1);
                end
                SEL: begin
                    for (int k = 0; k < S; k++)
                        result[k] <= (k < int'(n_r)) ? (use_d ? d_r[k] : t[k]) : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_cios_var.sv
// Directed vector bench for montgomery_cios_var at W=8, S=4.
module tb_montgomery_cios_var;

    localparam int W  = 8;
    localparam int S  = 4;
    localparam int NW = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [NW-1:0]       n_words;
    logic [S-1:0][W-1:0] a, b, m;
    logic [W-1:0]        m_prime;
    logic                out_valid;
    logic                out_ready;
    logic [S-1:0][W-1:0] result;
    logic                err;
    logic                busy;

    montgomery_cios_var #(.W(W), .S(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n_words   (n_words),
        .a         (a),
        .b         (b),
        .m         (m),
        .m_prime   (m_prime),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  n;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] m;
        logic [7:0]  mp;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs [11];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Waits for out_valid; returns the edge (counted from the accept edge) at which it is first sampled high.
    task automatic wait_out(input string name, output int lat);
        int cnt;
        cnt = 0;
        while (cnt < 200) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) break;
            cnt++;
        end
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: out_valid never rose", name);
        end
        lat = cnt + 1;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        n_words   = v.n;
        a         = v.a;
        b         = v.b;
        m         = v.m;
        m_prime   = v.mp;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int lat;
        apply(v);
        wait_out($sformatf("v%0d", id), lat);
        chk($sformatf("v%0d latency", id), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d result", id), result, v.res);
        chk($sformatf("v%0d err", id), {31'b0, err}, {31'b0, v.err});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("v%0d out_valid drop", id), {31'b0, out_valid}, 32'd0);
        chk($sformatf("v%0d in_ready back", id), {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int   lat;
        logic stale;

        // m=11: R=256, R mod 11 = 3, R^-1 mod 11 = 4.  Upper words are junk that must be ignored.
        vecs[0]  = '{3'd1, 32'hAAAAAA05, 32'h55555507, 32'hCCCCCC0B, 8'h5D, 32'h00000008, 1'b0, 8};
        vecs[1]  = '{3'd1, 32'h00000003, 32'h00000007, 32'h0000000B, 8'h5D, 32'h00000007, 1'b0, 8};
        vecs[2]  = '{3'd1, 32'h00000000, 32'h00000007, 32'h0000000B, 8'h5D, 32'h00000000, 1'b0, 8};
        vecs[3]  = '{3'd1, 32'h0000000A, 32'h0000000A, 32'h0000000B, 8'h5D, 32'h00000004, 1'b0, 8};
        // m = 2^(8n) - 5, so R mod m = 5 and a = 5 returns b; a = b = 5 returns 5.
        vecs[4]  = '{3'd4, 32'h00000005, 32'hFFFFFFFA, 32'hFFFFFFFB, 8'hCD, 32'hFFFFFFFA, 1'b0, 50};
        vecs[5]  = '{3'd4, 32'h00000005, 32'h00000005, 32'hFFFFFFFB, 8'hCD, 32'h00000005, 1'b0, 50};
        vecs[6]  = '{3'd2, 32'h99990005, 32'h77771234, 32'h3333FFFB, 8'hCD, 32'h00001234, 1'b0, 18};
        vecs[7]  = '{3'd3, 32'h11000005, 32'h22ABCDEF, 32'h44FFFFFB, 8'hCD, 32'h00ABCDEF, 1'b0, 32};
        vecs[8]  = '{3'd0, 32'h12345678, 32'h12345678, 32'hFFFFFFFB, 8'hCD, 32'h00000000, 1'b1, 1};
        vecs[9]  = '{3'd5, 32'h12345678, 32'h12345678, 32'hFFFFFFFB, 8'hCD, 32'h00000000, 1'b1, 1};
        vecs[10] = '{3'd1, 32'h00000005, 32'h00000007, 32'h0000000B, 8'h5D, 32'h00000008, 1'b0, 8};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_words   = '0;
        a         = '0;
        b         = '0;
        m         = '0;
        m_prime   = '0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset err", {31'b0, err}, 32'd0);
        chk("reset result", result, 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 11; k++) run_vec(vecs[k], k);

        // Back-pressure: result held for 10 cycles while a new request waits.
        apply(vecs[0]);
        wait_out("hold", lat);
        n_words  = 3'd1;
        a        = 32'h00000003;
        b        = 32'h00000007;
        m        = 32'h0000000B;
        m_prime  = 8'h5D;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d out_valid", k), {31'b0, out_valid}, 32'd1);
            chk($sformatf("hold%0d result", k), result, 32'h00000008);
            chk($sformatf("hold%0d err", k), {31'b0, err}, 32'd0);
            chk($sformatf("hold%0d in_ready", k), {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold release out_valid", {31'b0, out_valid}, 32'd0);
        chk("hold release not yet busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold second accepted", {31'b0, busy}, 32'd1);
        wait_out("hold second", lat);
        chk("hold second result", result, 32'h00000007);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset pulse while the n=4 operation is in its first reduction row.
        apply(vecs[4]);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort result", result, 32'd0);
        stale = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("abort no stale out_valid", {31'b0, stale}, 32'd0);
        run_vec(vecs[4], 11);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
